// File: rtl/cpu_amo_store_noc_xbar.sv
// -----------------------------------------------------------------------------
// cpu_amo_store_noc_pkg / cpu_amo_store_noc_xbar
//
// Crossbar that carries AMO/store requests from CPU_PORT_CNT sources to
// L2_PORT_CNT L2 banks.
//
// Data path: a per-source ingress FIFO feeds a per-bank round-robin arbiter,
// and the arbiter feeds a 2-entry bank egress FIFO. The ingress FIFO is
// BUF_IN_DEPTH deep.
//
// A per-source ordering lock keeps each source's requests leaving the
// crossbar in issue order. It does this by allowing a source to have
// entries outstanding in only one bank at a time.
//
// Ports
//   clk, rstn                     : clock, asynchronous active-low reset
//   cpu_amo_store_noc_req_valid   : per-source request valid (unpacked)
//   cpu_amo_store_noc_req_ready   : per-source ready, high when the ingress
//                                   FIFO is not full
//   cpu_amo_store_noc_req         : per-source request payload
//   l2_amo_store_req_valid/ready  : per-bank handshake
//   l2_amo_store_req              : per-bank payload; req_tid.cpu_noc_id
//                                   carries the source index
//   src_blocked                   : source head valid but held by the
//                                   ordering lock
// -----------------------------------------------------------------------------
package cpu_amo_store_noc_pkg;
  localparam int CACHE_OFFSET_WIDTH = 6;
  localparam int PADDR_W            = 40;
  localparam int NOC_ID_W           = 4;

  typedef struct packed {
    logic [NOC_ID_W-1:0] cpu_noc_id;
    logic [5:0]          txn_id;
  } cpu_cache_if_tid_t;

  typedef struct packed {
    logic [PADDR_W-1:0] paddr;
    logic [31:0]        data;
    logic [3:0]         amo_op;
    cpu_cache_if_tid_t  req_tid;
  } cpu_cache_if_req_t;
endpackage

module cpu_amo_store_noc_xbar
  import cpu_amo_store_noc_pkg::*;
#(
  parameter int CPU_PORT_CNT = 8,
  parameter int L2_PORT_CNT  = 8,
  parameter int BUF_IN_DEPTH = 2,
  parameter int BANK_SEL_LSB = CACHE_OFFSET_WIDTH,
  parameter int HASH_MODE    = 0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    cpu_amo_store_noc_req_valid [CPU_PORT_CNT],
  output logic [CPU_PORT_CNT-1:0] cpu_amo_store_noc_req_ready,
  input  cpu_cache_if_req_t       cpu_amo_store_noc_req [CPU_PORT_CNT],
  output logic [L2_PORT_CNT-1:0]  l2_amo_store_req_valid,
  input  logic [L2_PORT_CNT-1:0]  l2_amo_store_req_ready,
  output cpu_cache_if_req_t       l2_amo_store_req [L2_PORT_CNT],
  output logic [CPU_PORT_CNT-1:0] src_blocked
);
  localparam int BW  = $clog2(L2_PORT_CNT);
  localparam int SW  = $clog2(CPU_PORT_CNT);
  localparam int IPW = (BUF_IN_DEPTH > 1) ? $clog2(BUF_IN_DEPTH) : 1;
  localparam int ICW = $clog2(BUF_IN_DEPTH + 1);

  // Ingress FIFO state
  cpu_cache_if_req_t in_mem_q  [CPU_PORT_CNT][BUF_IN_DEPTH];
  logic [IPW-1:0]    in_rd_q   [CPU_PORT_CNT];
  logic [IPW-1:0]    in_rd_d   [CPU_PORT_CNT];
  logic [IPW-1:0]    in_wr_q   [CPU_PORT_CNT];
  logic [IPW-1:0]    in_wr_d   [CPU_PORT_CNT];
  logic [ICW-1:0]    in_cnt_q  [CPU_PORT_CNT];
  logic [ICW-1:0]    in_cnt_d  [CPU_PORT_CNT];
  cpu_cache_if_req_t in_wdata  [CPU_PORT_CNT];
  cpu_cache_if_req_t head      [CPU_PORT_CNT];
  logic [BW-1:0]     head_bank [CPU_PORT_CNT];
  logic [CPU_PORT_CNT-1:0] in_push;
  logic [CPU_PORT_CNT-1:0] head_vld;
  logic [CPU_PORT_CNT-1:0] eligible;
  logic [CPU_PORT_CNT-1:0] src_grant;
  logic [CPU_PORT_CNT-1:0] src_dec;

  // Ordering lock state
  logic [1:0]    out_cnt_q   [CPU_PORT_CNT];
  logic [1:0]    out_cnt_d   [CPU_PORT_CNT];
  logic [BW-1:0] lock_bank_q [CPU_PORT_CNT];
  logic [BW-1:0] lock_bank_d [CPU_PORT_CNT];

  // Bank egress FIFO and arbiter state
  cpu_cache_if_req_t bk_mem_q [L2_PORT_CNT][2];
  logic [SW-1:0]     bk_src_q [L2_PORT_CNT][2];
  logic [1:0]        bk_cnt_q [L2_PORT_CNT];
  logic [1:0]        bk_cnt_d [L2_PORT_CNT];
  logic [SW-1:0]     bk_win   [L2_PORT_CNT];
  logic [SW-1:0]     rr_ptr_q [L2_PORT_CNT];
  logic [SW-1:0]     rr_ptr_d [L2_PORT_CNT];
  logic [L2_PORT_CNT-1:0] bk_rd_q, bk_rd_d;
  logic [L2_PORT_CNT-1:0] bk_wr_q, bk_wr_d;
  logic [L2_PORT_CNT-1:0] bk_push, bk_pop, bk_can_push;

  function automatic logic [BW-1:0] bank_of(input logic [PADDR_W-1:0] paddr);
    logic [BW-1:0] b;
    b = paddr[BANK_SEL_LSB +: BW];
    if (HASH_MODE != 0) begin
      b = b ^ paddr[BANK_SEL_LSB+BW +: BW] ^ paddr[BANK_SEL_LSB+2*BW +: BW];
    end
    return b;
  endfunction

  // Wraps at BUF_IN_DEPTH so that non power-of-two depths work.
  function automatic logic [IPW-1:0] next_in_ptr(input logic [IPW-1:0] p);
    if (int'(p) == BUF_IN_DEPTH - 1) begin
      return '0;
    end
    return p + IPW'(1);
  endfunction

  // ---- ingress stage: FIFO head, bank select, ordering lock eligibility ----
  always_comb begin
    for (int s = 0; s < CPU_PORT_CNT; s++) begin
      // The full flag comes from a register only, so ready never sees l2 ready.
      // A pop in the same cycle does not make room for a write.
      cpu_amo_store_noc_req_ready[s] = (in_cnt_q[s] != ICW'(BUF_IN_DEPTH));
      in_push[s]  = cpu_amo_store_noc_req_valid[s] && (in_cnt_q[s] != ICW'(BUF_IN_DEPTH));
      in_wdata[s] = cpu_amo_store_noc_req[s];
      in_wdata[s].req_tid.cpu_noc_id = NOC_ID_W'(s);
      head[s]      = in_mem_q[s][in_rd_q[s]];
      head_vld[s]  = (in_cnt_q[s] != '0);
      head_bank[s] = bank_of(head[s].paddr);
      eligible[s]  = head_vld[s] &&
                     ((out_cnt_q[s] == 2'd0) || (lock_bank_q[s] == head_bank[s]));
      src_blocked[s] = head_vld[s] && !eligible[s];
    end
  end

  // ---- arbitration stage: per-bank round robin into the egress FIFO ----
  always_comb begin
    int idx;
    src_grant = '0;
    for (int b = 0; b < L2_PORT_CNT; b++) begin
      bk_pop[b] = (bk_cnt_q[b] != 2'd0) && l2_amo_store_req_ready[b];
      // A full FIFO that is popping this cycle still takes a new entry.
      bk_can_push[b] = (bk_cnt_q[b] != 2'd2) || bk_pop[b];
      bk_push[b] = 1'b0;
      bk_win[b]  = '0;
      for (int k = 0; k < CPU_PORT_CNT; k++) begin
        idx = int'(rr_ptr_q[b]) + k;
        if (idx >= CPU_PORT_CNT) begin
          idx = idx - CPU_PORT_CNT;
        end
        if (!bk_push[b] && bk_can_push[b] && eligible[idx] &&
            (head_bank[idx] == BW'(b))) begin
          bk_push[b]     = 1'b1;
          bk_win[b]      = SW'(idx);
          src_grant[idx] = 1'b1;
        end
      end
    end
  end

  // ---- egress stage: bank FIFO head drives the L2 port ----
  always_comb begin
    src_dec = '0;
    for (int b = 0; b < L2_PORT_CNT; b++) begin
      l2_amo_store_req_valid[b] = (bk_cnt_q[b] != 2'd0);
      l2_amo_store_req[b]       = bk_mem_q[b][bk_rd_q[b]];
      if (bk_pop[b]) begin
        src_dec[bk_src_q[b][bk_rd_q[b]]] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int s = 0; s < CPU_PORT_CNT; s++) begin
      in_wr_d[s]  = in_push[s]   ? next_in_ptr(in_wr_q[s]) : in_wr_q[s];
      in_rd_d[s]  = src_grant[s] ? next_in_ptr(in_rd_q[s]) : in_rd_q[s];
      in_cnt_d[s] = in_cnt_q[s] + ICW'(in_push[s]) - ICW'(src_grant[s]);
      // Accept and leave in the same cycle cancel out.
      out_cnt_d[s]   = out_cnt_q[s] + 2'(src_grant[s]) - 2'(src_dec[s]);
      lock_bank_d[s] = src_grant[s] ? head_bank[s] : lock_bank_q[s];
    end
    for (int b = 0; b < L2_PORT_CNT; b++) begin
      bk_wr_d[b]  = bk_wr_q[b] ^ bk_push[b];
      bk_rd_d[b]  = bk_rd_q[b] ^ bk_pop[b];
      bk_cnt_d[b] = bk_cnt_q[b] + 2'(bk_push[b]) - 2'(bk_pop[b]);
      rr_ptr_d[b] = rr_ptr_q[b];
      if (bk_push[b]) begin
        rr_ptr_d[b] = (int'(bk_win[b]) == CPU_PORT_CNT - 1) ? '0 : bk_win[b] + SW'(1);
      end
    end
  end

  // Only control state is reset; FIFO contents are ignored once pointers clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int s = 0; s < CPU_PORT_CNT; s++) begin
        in_rd_q[s]     <= '0;
        in_wr_q[s]     <= '0;
        in_cnt_q[s]    <= '0;
        out_cnt_q[s]   <= '0;
        lock_bank_q[s] <= '0;
      end
      for (int b = 0; b < L2_PORT_CNT; b++) begin
        bk_cnt_q[b] <= '0;
        rr_ptr_q[b] <= '0;
      end
      bk_rd_q <= '0;
      bk_wr_q <= '0;
    end else begin
      for (int s = 0; s < CPU_PORT_CNT; s++) begin
        in_rd_q[s]     <= in_rd_d[s];
        in_wr_q[s]     <= in_wr_d[s];
        in_cnt_q[s]    <= in_cnt_d[s];
        out_cnt_q[s]   <= out_cnt_d[s];
        lock_bank_q[s] <= lock_bank_d[s];
      end
      for (int b = 0; b < L2_PORT_CNT; b++) begin
        bk_cnt_q[b] <= bk_cnt_d[b];
        rr_ptr_q[b] <= rr_ptr_d[b];
      end
      bk_rd_q <= bk_rd_d;
      bk_wr_q <= bk_wr_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < CPU_PORT_CNT; s++) begin
      if (in_push[s]) begin
        in_mem_q[s][in_wr_q[s]] <= in_wdata[s];
      end
    end
    for (int b = 0; b < L2_PORT_CNT; b++) begin
      if (bk_push[b]) begin
        bk_mem_q[b][bk_wr_q[b]] <= head[bk_win[b]];
        bk_src_q[b][bk_wr_q[b]] <= bk_win[b];
      end
    end
  end

endmodule

// File: tb/tb_cpu_amo_store_noc_xbar.sv
module tb_cpu_amo_store_noc_xbar;
  import cpu_amo_store_noc_pkg::*;

  localparam int NS   = 8;
  localparam int NB   = 8;
  localparam int BWT  = $clog2(NB);
  localparam int LSB  = CACHE_OFFSET_WIDTH;
  localparam int HNS  = 4;
  localparam int HNB  = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic              cpu_vld [NS];
  logic [NS-1:0]     cpu_rdy;
  cpu_cache_if_req_t cpu_req [NS];
  logic [NB-1:0]     l2_vld;
  logic [NB-1:0]     l2_rdy;
  cpu_cache_if_req_t l2_req [NB];
  logic [NS-1:0]     blk;

  logic              h_vld [HNS];
  logic [HNS-1:0]    h_rdy;
  cpu_cache_if_req_t h_req [HNS];
  logic [HNB-1:0]    h_l2_vld;
  logic [HNB-1:0]    h_l2_rdy;
  cpu_cache_if_req_t h_l2_req [HNB];
  logic [HNS-1:0]    h_blk;

  cpu_amo_store_noc_xbar #(
    .CPU_PORT_CNT(NS), .L2_PORT_CNT(NB), .BUF_IN_DEPTH(2), .HASH_MODE(0)
  ) u_dut (
    .clk(clk), .rstn(rstn),
    .cpu_amo_store_noc_req_valid(cpu_vld),
    .cpu_amo_store_noc_req_ready(cpu_rdy),
    .cpu_amo_store_noc_req(cpu_req),
    .l2_amo_store_req_valid(l2_vld),
    .l2_amo_store_req_ready(l2_rdy),
    .l2_amo_store_req(l2_req),
    .src_blocked(blk)
  );

  cpu_amo_store_noc_xbar #(
    .CPU_PORT_CNT(HNS), .L2_PORT_CNT(HNB), .BUF_IN_DEPTH(2), .HASH_MODE(1)
  ) u_hash (
    .clk(clk), .rstn(rstn),
    .cpu_amo_store_noc_req_valid(h_vld),
    .cpu_amo_store_noc_req_ready(h_rdy),
    .cpu_amo_store_noc_req(h_req),
    .l2_amo_store_req_valid(h_l2_vld),
    .l2_amo_store_req_ready(h_l2_rdy),
    .l2_amo_store_req(h_l2_req),
    .src_blocked(h_blk)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: per-source pending sends, per-source expected egress
  // order, and logs of which source left on which bank.
  cpu_cache_if_req_t send_q [NS][$];
  cpu_cache_if_req_t exp_q  [NS][$];
  int                egr_src  [NB][$];
  int                egr_bank [NS][$];
  logic [NB-1:0]     prev_stall;
  cpu_cache_if_req_t prev_req [NB];

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ref_bank(input logic [PADDR_W-1:0] pa, input int nb, input int hash);
    longint unsigned a;
    longint unsigned m;
    int bw;
    a  = 64'(pa);
    m  = 64'(nb);
    bw = $clog2(nb);
    if (hash != 0) begin
      return int'(((a >> LSB) ^ (a >> (LSB + bw)) ^ (a >> (LSB + 2 * bw))) % m);
    end
    return int'((a >> LSB) % m);
  endfunction

  function automatic cpu_cache_if_req_t rand_req(input int bank);
    cpu_cache_if_req_t r;
    r.paddr = PADDR_W'({$urandom, $urandom});
    r.paddr[LSB +: BWT] = BWT'(bank);
    r.data = $urandom;
    r.amo_op = 4'($urandom);
    r.req_tid.cpu_noc_id = NOC_ID_W'($urandom);
    r.req_tid.txn_id = 6'($urandom);
    return r;
  endfunction

  function automatic int pending();
    int n;
    n = 0;
    for (int s = 0; s < NS; s++) begin
      n += send_q[s].size() + exp_q[s].size();
    end
    return n;
  endfunction

  task automatic clear_logs();
    for (int b = 0; b < NB; b++) egr_src[b].delete();
    for (int s = 0; s < NS; s++) egr_bank[s].delete();
  endtask

  // One clock: present pending sends, record both handshakes, then advance.
  task automatic tick();
    cpu_cache_if_req_t e;
    int src;
    for (int s = 0; s < NS; s++) begin
      if (send_q[s].size() > 0) begin
        cpu_vld[s] = 1'b1;
        cpu_req[s] = send_q[s][0];
      end else begin
        cpu_vld[s] = 1'b0;
      end
    end
    for (int s = 0; s < NS; s++) begin
      if (cpu_vld[s] && cpu_rdy[s]) begin
        e = send_q[s].pop_front();
        e.req_tid.cpu_noc_id = NOC_ID_W'(s);
        exp_q[s].push_back(e);
      end
    end
    for (int b = 0; b < NB; b++) begin
      if (prev_stall[b]) begin
        check_val("hold_valid", 128'(l2_vld[b]), 128'(1));
        check_val("hold_payload", 128'(l2_req[b]), 128'(prev_req[b]));
      end
      if (l2_vld[b] && l2_rdy[b]) begin
        src = int'(l2_req[b].req_tid.cpu_noc_id);
        if (src < NS) begin
          check_val("egress_expected", 128'(exp_q[src].size() > 0), 128'(1));
          if (exp_q[src].size() > 0) begin
            e = exp_q[src].pop_front();
            check_val("egress_payload", 128'(l2_req[b]), 128'(e));
            check_val("egress_bank", 128'(b), 128'(ref_bank(e.paddr, NB, 0)));
          end
          egr_bank[src].push_back(b);
        end else begin
          check_val("egress_src_range", 128'(src < NS), 128'(1));
        end
        egr_src[b].push_back(src);
      end
      prev_stall[b] = l2_vld[b] && !l2_rdy[b];
      prev_req[b]   = l2_req[b];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (pending() != 0 && guard < 1000) begin
      tick();
      guard++;
    end
    check_val("drain_empty", 128'(pending()), 128'(0));
    check_val("drain_idle", 128'(l2_vld), 128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cpu_cache_if_req_t ra, rb, rc, hr;
    int cnt [3];
    int hs, hb;
    for (int s = 0; s < NS; s++) begin
      cpu_vld[s] = 1'b0;
      cpu_req[s] = '0;
    end
    for (int s = 0; s < HNS; s++) begin
      h_vld[s] = 1'b0;
      h_req[s] = '0;
    end
    l2_rdy = '1;
    h_l2_rdy = '1;
    prev_stall = '0;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #2;
    check_val("rst_l2_valid", 128'(l2_vld), 128'(0));
    check_val("rst_blocked", 128'(blk), 128'(0));
    check_val("rst_cpu_ready", 128'(cpu_rdy), 128'({NS{1'b1}}));
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk);
    #1;

    // Single request: source 3 to bank 5, two-cycle latency.
    clear_logs();
    ra = rand_req(5);
    send_q[3].push_back(ra);
    tick();
    check_val("single_c1_valid", 128'(l2_vld), 128'(0));
    tick();
    check_val("single_c2_valid", 128'(l2_vld), 128'(NB'(1) << 5));
    check_val("single_noc_id", 128'(l2_req[5].req_tid.cpu_noc_id), 128'(3));
    ra.req_tid.cpu_noc_id = 3;
    check_val("single_payload", 128'(l2_req[5]), 128'(ra));
    drain();

    // Round robin: sources 0,1,2 stream to bank 4.
    clear_logs();
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < 12; k++) send_q[s].push_back(rand_req(4));
    drain();
    check_val("rr_count", 128'(egr_src[4].size()), 128'(36));
    for (int i = 0; i < 3; i++) cnt[i] = 0;
    for (int i = 0; i < 30 && i < egr_src[4].size(); i++) begin
      check_val("rr_order", 128'(egr_src[4][i]), 128'(i % 3));
      if (egr_src[4][i] < 3) cnt[egr_src[4][i]]++;
    end
    for (int i = 0; i < 3; i++) check_val("rr_share", 128'(cnt[i]), 128'(10));

    // Ordering lock: A to bank 1 (stalled), B to bank 2; source 1 unaffected.
    clear_logs();
    ra = rand_req(1);
    rb = rand_req(2);
    rc = rand_req(2);
    send_q[0].push_back(ra);
    send_q[0].push_back(rb);
    send_q[1].push_back(rc);
    l2_rdy[1] = 1'b0;
    repeat (4) tick();
    check_val("lock_blocked", 128'(blk[0]), 128'(1));
    check_val("lock_other_free", 128'(blk[1]), 128'(0));
    for (int i = 0; i < 6; i++) begin
      tick();
      check_val("lock_blocked_hold", 128'(blk[0]), 128'(1));
      check_val("lock_b_held", 128'(l2_vld[2]), 128'(0));
    end
    check_val("lock_other_src", 128'(egr_bank[1].size()), 128'(1));
    l2_rdy[1] = 1'b1;
    drain();
    check_val("lock_src0_count", 128'(egr_bank[0].size()), 128'(2));
    if (egr_bank[0].size() == 2) begin
      check_val("lock_first_bank", 128'(egr_bank[0][0]), 128'(1));
      check_val("lock_second_bank", 128'(egr_bank[0][1]), 128'(2));
    end

    // Backpressure: 5 requests into a stalled bank 0.
    clear_logs();
    l2_rdy[0] = 1'b0;
    for (int k = 0; k < 5; k++) send_q[0].push_back(rand_req(0));
    repeat (8) tick();
    check_val("bp_cpu_ready", 128'(cpu_rdy[0]), 128'(0));
    check_val("bp_unaccepted", 128'(send_q[0].size()), 128'(1));
    check_val("bp_bank_valid", 128'(l2_vld[0]), 128'(1));
    check_val("bp_not_blocked", 128'(blk[0]), 128'(0));
    l2_rdy[0] = 1'b1;
    drain();
    check_val("bp_delivered", 128'(egr_bank[0].size()), 128'(5));

    // Hash mode: fields 01/10/11 fold to bank 0, then random addresses.
    hr = rand_req(0);
    hr.paddr[LSB +: 6] = 6'b11_10_01;
    h_req[1] = hr;
    h_vld[1] = 1'b1;
    tick();
    h_vld[1] = 1'b0;
    tick();
    check_val("hash_fold_bank", 128'(h_l2_vld), 128'(4'b0001));
    check_val("hash_fold_noc_id", 128'(h_l2_req[0].req_tid.cpu_noc_id), 128'(1));
    tick();
    for (int i = 0; i < 8; i++) begin
      hr = rand_req(0);
      hr.paddr = PADDR_W'({$urandom, $urandom});
      hs = $urandom_range(0, HNS - 1);
      hb = ref_bank(hr.paddr, HNB, 1);
      check_val("hash_ready", 128'(h_rdy[hs]), 128'(1));
      h_req[hs] = hr;
      h_vld[hs] = 1'b1;
      tick();
      h_vld[hs] = 1'b0;
      tick();
      check_val("hash_bank", 128'(h_l2_vld), 128'(HNB'(1) << hb));
      check_val("hash_paddr", 128'(h_l2_req[hb].paddr), 128'(hr.paddr));
      tick();
    end

    // Randomized traffic with random bank backpressure.
    clear_logs();
    for (int c = 0; c < 600; c++) begin
      for (int s = 0; s < NS; s++)
        if ($urandom_range(0, 3) == 0 && send_q[s].size() < 4)
          send_q[s].push_back(rand_req($urandom_range(0, NB - 1)));
      for (int b = 0; b < NB; b++) l2_rdy[b] = ($urandom_range(0, 3) != 0);
      tick();
    end
    l2_rdy = '1;
    drain();

    // Asynchronous reset with FIFOs partly full.
    for (int k = 0; k < 3; k++) send_q[5].push_back(rand_req(4));
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 3; k++) send_q[s].push_back(rand_req($urandom_range(0, 3)));
    l2_rdy = '0;
    repeat (5) tick();
    #2 rstn = 1'b0;
    #1;
    check_val("arst_l2_valid", 128'(l2_vld), 128'(0));
    check_val("arst_blocked", 128'(blk), 128'(0));
    check_val("arst_cpu_ready", 128'(cpu_rdy), 128'({NS{1'b1}}));
    for (int s = 0; s < NS; s++) begin
      send_q[s].delete();
      exp_q[s].delete();
      cpu_vld[s] = 1'b0;
    end
    prev_stall = '0;
    l2_rdy = '1;
    @(negedge clk) rstn = 1'b1;
    @(posedge clk);
    #1;
    clear_logs();
    send_q[7].push_back(rand_req(4));
    send_q[1].push_back(rand_req(4));
    tick();
    check_val("arst_c1_valid", 128'(l2_vld), 128'(0));
    tick();
    check_val("arst_c2_valid", 128'(l2_vld), 128'(NB'(1) << 4));
    check_val("arst_rr_first", 128'(l2_req[4].req_tid.cpu_noc_id), 128'(1));
    drain();
    check_val("arst_order_len", 128'(egr_src[4].size()), 128'(2));
    if (egr_src[4].size() == 2)
      check_val("arst_rr_second", 128'(egr_src[4][1]), 128'(7));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
